// File: rtl/reg_scoreboard.sv
// reg_scoreboard: pending-write scoreboard that stalls issue on RAW/overflow hazards and supports a drain handshake
// Ports: clk, reset (async, active-high); issue_valid/issue_src1/issue_src2/issue_dst in, issue_ready out;
//        wb_valid/wb_dst writeback in; drain_req in, drain_done one-cycle pulse out;
//        busy_mask[i] = register i has pending writes; err = sticky protocol error.
module reg_scoreboard #(
    parameter int NREGS = 18,
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [7:0]       issue_src1,
    input  logic [7:0]       issue_src2,
    input  logic [7:0]       issue_dst,
    output logic             issue_ready,
    input  logic             wb_valid,
    input  logic [7:0]       wb_dst,
    input  logic             drain_req,
    output logic             drain_done,
    output logic [NREGS-1:0] busy_mask,
    output logic             err
);
    localparam logic [0:0] RUN      = 1'b0;
    localparam logic [0:0] DRAIN    = 1'b1;
    localparam logic [6:0] NREGS_ID = 7'(NREGS);

    function automatic logic trk(input logic [7:0] id);
        return id[7] && (id[6:0] < NREGS_ID);
    endfunction

    // Real-register encoding but beyond the file: behaves as fake, flagged as error.
    function automatic logic inv(input logic [7:0] id);
        return id[7] && (id[6:0] >= NREGS_ID);
    endfunction

    logic [CNT_W-1:0] cnt_q [NREGS];
    logic [CNT_W-1:0] cnt_d [NREGS];
    logic [0:0]       state_q, state_d;
    logic             err_q, err_d, drain_done_q, drain_done_d;
    logic             raw, ovf, accept, inc, dec;

    always_comb begin
        busy_mask = '0;
        raw = 1'b0;
        ovf = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            busy_mask[i] = cnt_q[i] != '0;
            if ((trk(issue_src1) && issue_src1[6:0] == 7'(i)) || (trk(issue_src2) && issue_src2[6:0] == 7'(i)))
                raw = raw | busy_mask[i];
            if (trk(issue_dst) && issue_dst[6:0] == 7'(i) && cnt_q[i] == '1)
                ovf = 1'b1;
        end
        issue_ready = (state_q == RUN) && !raw && !ovf;
        accept = issue_valid && issue_ready;
        cnt_d = cnt_q;
        err_d = err_q || (accept && (inv(issue_src1) || inv(issue_src2) || inv(issue_dst)))
                      || (wb_valid && inv(wb_dst));
        inc = 1'b0;
        dec = 1'b0;
        for (int i = 0; i < NREGS; i++) begin
            inc = accept && trk(issue_dst) && issue_dst[6:0] == 7'(i);
            dec = wb_valid && trk(wb_dst) && wb_dst[6:0] == 7'(i);
            // Underflow is judged on the old count, so a same-cycle issue cannot mask it.
            if (dec && cnt_q[i] == '0)
                err_d = 1'b1;
            else if (inc && !dec)
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            else if (dec && !inc)
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
        end
        state_d = (state_q == RUN) ? (drain_req ? DRAIN : RUN) : (busy_mask == '0 ? RUN : DRAIN);
        drain_done_d = (state_q == DRAIN) && (busy_mask == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) cnt_q[i] <= '0;
            state_q      <= RUN;
            err_q        <= 1'b0;
            drain_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            err_q        <= err_d;
            drain_done_q <= drain_done_d;
        end
    end

    assign drain_done = drain_done_q;
    assign err        = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed self-checking bench for reg_scoreboard
module tb_reg_scoreboard;
    localparam logic [7:0] RNIL = 8'h00, RIP = 8'h01, RIMM = 8'h02;
    localparam logic [7:0] RAX = 8'h80, RCX = 8'h81, RDX = 8'h82, RBX = 8'h83, RBAD = 8'h92;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        issue_valid = 1'b0;
    logic [7:0]  issue_src1 = RNIL, issue_src2 = RNIL, issue_dst = RNIL;
    logic        issue_ready;
    logic        wb_valid = 1'b0;
    logic [7:0]  wb_dst = RNIL;
    logic        drain_req = 1'b0;
    logic        drain_done;
    logic [17:0] busy_mask;
    logic        err;
    int          n_chk = 0, n_pass = 0;

    reg_scoreboard #(.NREGS(18), .CNT_W(2)) dut (
        .clk(clk), .reset(reset),
        .issue_valid(issue_valid), .issue_src1(issue_src1), .issue_src2(issue_src2),
        .issue_dst(issue_dst), .issue_ready(issue_ready),
        .wb_valid(wb_valid), .wb_dst(wb_dst),
        .drain_req(drain_req), .drain_done(drain_done),
        .busy_mask(busy_mask), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_src1 = RNIL;
        issue_src2 = RNIL;
        issue_dst = RNIL;
        wb_valid = 1'b0;
        wb_dst = RNIL;
        drain_req = 1'b0;
    endtask

    task automatic issue(input logic [7:0] dst);
        idle();
        issue_valid = 1'b1;
        issue_dst = dst;
    endtask

    task automatic wb(input logic [7:0] dst);
        idle();
        wb_valid = 1'b1;
        wb_dst = dst;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        #2;
        reset = 1'b0;
        tick();
    endtask

    initial begin
        idle();
        tick();
        tick();
        reset = 1'b0;
        #1;
        chk("rst_busy", 32'(busy_mask), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_done", 32'(drain_done), 0);
        chk("rst_ready", 32'(issue_ready), 1);

        // RAW on rax, cleared by writeback with one cycle latency
        issue(RAX); #1;
        chk("rax_ready", 32'(issue_ready), 1);
        tick();
        idle(); #1;
        chk("rax_busy", 32'(busy_mask), 32'h1);
        issue_src1 = RAX; #1;
        chk("raw_stall", 32'(issue_ready), 0);
        wb_valid = 1'b1; wb_dst = RAX; #1;
        chk("raw_no_bypass", 32'(issue_ready), 0);
        tick();
        wb_valid = 1'b0; #1;
        chk("raw_clear", 32'(issue_ready), 1);
        chk("raw_busy0", 32'(busy_mask), 0);

        // WAW up to the counter max, then overflow stall
        for (int k = 0; k < 3; k++) begin
            issue(RCX); #1;
            chk("waw_ready", 32'(issue_ready), 1);
            tick();
        end
        idle(); #1;
        chk("waw_busy", 32'(busy_mask), 32'h2);
        issue(RCX); #1;
        chk("ovf_stall", 32'(issue_ready), 0);
        wb_valid = 1'b1; wb_dst = RCX; #1;
        chk("ovf_no_bypass", 32'(issue_ready), 0);
        tick();
        wb_valid = 1'b0; #1;
        chk("ovf_clear", 32'(issue_ready), 1);
        tick();
        issue(RCX); #1;
        chk("ovf_again", 32'(issue_ready), 0);
        for (int k = 0; k < 3; k++) begin
            wb(RCX);
            tick();
        end
        idle(); #1;
        chk("rcx_drained", 32'(busy_mask), 0);
        chk("rcx_err", 32'(err), 0);

        // same-cycle issue + writeback on rdx
        issue(RDX);
        tick();
        issue(RDX); wb_valid = 1'b1; wb_dst = RDX; #1;
        chk("same1_ready", 32'(issue_ready), 1);
        tick();
        idle(); #1;
        chk("same1_busy", 32'(busy_mask), 32'h4);
        chk("same1_err", 32'(err), 0);
        wb(RDX);
        tick();
        issue(RDX); wb_valid = 1'b1; wb_dst = RDX;
        tick();
        idle(); #1;
        chk("same0_busy", 32'(busy_mask), 0);
        chk("same0_err", 32'(err), 1);
        do_reset();
        chk("rst2_err", 32'(err), 0);

        // fake and invalid ids
        issue(RNIL); issue_src1 = RIP; issue_src2 = RIMM; #1;
        chk("fake_ready", 32'(issue_ready), 1);
        tick();
        idle(); #1;
        chk("fake_busy", 32'(busy_mask), 0);
        chk("fake_err", 32'(err), 0);
        issue(RBAD); #1;
        chk("inv_ready", 32'(issue_ready), 1);
        tick();
        idle(); #1;
        chk("inv_busy", 32'(busy_mask), 0);
        chk("inv_err", 32'(err), 1);
        do_reset();

        // drain with pending rax/rbx; issue in cycle N is accepted
        issue(RAX);
        tick();
        issue(RBX);
        tick();
        issue(RDX); drain_req = 1'b1; #1;
        chk("drainN_ready", 32'(issue_ready), 1);
        tick();
        for (int c = 1; c <= 8; c++) begin
            idle();
            if (c == 3) wb(RAX);
            if (c == 4) wb(RDX);
            if (c == 5) wb(RBX);
            #1;
            if (c == 1) chk("drainN_busy", 32'(busy_mask), 32'hD);
            chk($sformatf("drain_ready_c%0d", c), 32'(issue_ready), 32'(c >= 7));
            chk($sformatf("drain_done_c%0d", c), 32'(drain_done), 32'(c == 7));
            tick();
        end
        chk("drain_err", 32'(err), 0);

        // immediate empty drain: DRAIN for N+1 only, done at N+2 only
        idle(); drain_req = 1'b1;
        tick();
        idle(); #1;
        chk("empty_n1_ready", 32'(issue_ready), 0);
        chk("empty_n1_done", 32'(drain_done), 0);
        tick();
        chk("empty_n2_ready", 32'(issue_ready), 1);
        chk("empty_n2_done", 32'(drain_done), 1);
        tick();
        chk("empty_n3_done", 32'(drain_done), 0);

        // async reset in the middle of a drain
        wb(RCX);
        tick();
        issue(RAX);
        tick();
        idle(); drain_req = 1'b1;
        tick();
        idle(); #1;
        chk("mid_pre_ready", 32'(issue_ready), 0);
        chk("mid_pre_err", 32'(err), 1);
        #2;
        reset = 1'b1; #1;
        chk("mid_busy", 32'(busy_mask), 0);
        chk("mid_err", 32'(err), 0);
        chk("mid_done", 32'(drain_done), 0);
        chk("mid_ready", 32'(issue_ready), 1);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("post_rst_done", 32'(drain_done), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Tracks in-flight register writes for the x86-64 core's register file. It stalls instruction issue on read-after-write hazards and clears pending state on writeback. It also provides a drain sequence so the pipeline can be quiesced before a flush or trap. It sits between decode/issue and the register file writeback port, and it uses the 8-bit `RegMap::reg_id_t` encoding.

## Interface
Parameters:
- NREGS, 18, number of tracked real registers (equals `RegMap::REG_FILE_SIZE`)
- CNT_W, 2, width of each pending-write counter (max outstanding writes per register = 2^CNT_W-1)

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- issue_valid  in  1  issue request
- issue_src1  in  8  source reg id (reg_id_t encoding)
- issue_src2  in  8  source reg id
- issue_dst  in  8  destination reg id
- issue_ready  out  1  issue may be accepted this cycle
- wb_valid  in  1  writeback completing this cycle
- wb_dst  in  8  writeback reg id
- drain_req  in  1  request to quiesce (pulse or level)
- drain_done  out  1  one-cycle pulse when drain completes
- busy_mask  out  NREGS  bit i = counter[i] != 0
- err  out  1  sticky protocol error flag

## Operation
- Register classification:
  - An id is tracked when id[7]=1 and id[6:0] < NREGS.
  - Fake ids (rnil, rip, rimm; id[7]=0) never stall and are never counted.
  - An id with id[7]=1 and id[6:0] >= NREGS is "invalid". It is treated as fake, and it sets err if it appears on an accepted issue or on a writeback.
- State: NREGS counters of CNT_W bits; FSM {RUN, DRAIN}; err; drain_done register.
- Hazard (combinational, from registered counters only; no writeback bypass):
  - RAW: src1 or src2 is tracked with counter != 0.
  - OVF: dst is tracked with counter == max.
- issue_ready = (state==RUN) && !RAW && !OVF. It is evaluated on the current issue_* fields, even when issue_valid=0.
- Accept = issue_valid && issue_ready. On accept with a tracked dst, counter[dst] increments.
- WAW is permitted up to counter max. Writebacks are assumed in order per register.
- Writeback with wb_valid and tracked wb_dst:
  - Counter nonzero: counter[wb_dst] decrements.
  - Counter zero: counter unchanged, err set (underflow).
- Accept and writeback to the same register in the same cycle: the counter is unchanged. The underflow check uses the pre-update value, so 0 with +1/-1 gives 0 and sets err.
- dst equal to src is legal. The hazard check uses the old counter, and the dst increment applies after the check.
- FSM:
  - RUN: drain_req=1 goes to DRAIN next cycle. An issue in the same cycle as drain_req is still accepted.
  - DRAIN: issue_ready=0. Writebacks are processed normally. drain_req is ignored. When all counters == 0 (registered value), go to RUN next cycle and set drain_done=1 for that one cycle.
- Reset mid-operation clears all state immediately, regardless of FSM state or in-flight writes.

## Timing
- Reset values:
  - Counters 0, busy_mask 0, state RUN, drain_done 0, err 0.
  - issue_ready = 1 whenever the issue fields contain no hazard, which is every cycle after reset because all counters are 0.
- A counter update is visible on busy_mask and in the hazard check the cycle after accept or writeback.
- Writeback-to-unstall latency is 1 cycle: a wb in cycle N makes issue_ready=1 in N+1.
- Drain with counters already 0:
  - drain_req in cycle N: DRAIN in N+1, RUN in N+2, drain_done=1 in N+2 only.
  - issue_ready=0 in N+1 only.
- err is sticky until reset.
- All outputs except issue_ready are registered.

## Test plan
- Reset, then issue dst=rax(0x80), src=rnil, rnil: accepted, busy_mask=0x00001 next cycle. Issue src1=rax: issue_ready=0. wb rax: issue_ready=1 one cycle later.
- Issue dst=rcx three times with no wb: all accepted, counter=3. Fourth issue dst=rcx: issue_ready=0 (OVF). One wb rcx: accepted the next cycle.
- Issue dst=rdx and wb rdx in the same cycle with counter=1: counter stays 1 and err=0. Repeat with counter=0: counter stays 0 and err=1.
- Srcs rip/rimm and dst=rnil: always ready, busy_mask unchanged. Issue dst=0x92 (invalid): accepted, busy_mask unchanged, err=1.
- Drain: counters rax=1 and rbx=1, drain_req pulse in cycle N. issue_ready=0 from N+1. wb rax at N+3 and wb rbx at N+5 give RUN and drain_done=1 at N+7 only. An issue in cycle N is accepted.
- Reset asserted asynchronously mid-DRAIN with counters nonzero: busy_mask=0, err=0, drain_done=0, state RUN immediately. No drain_done pulse follows.
